// File: rtl/layer_compositor.sv
// Merges NUM_LAYERS pixel streams by fixed index priority with per-layer enable and blink,
// pipelining pixel, winner index and VGA sync/DE together; latches a per-frame overlap flag.
module layer_compositor #(
    parameter int                 NUM_LAYERS   = 4,
    parameter int                 COLOR_W      = 12,
    parameter int                 PIPE_STAGES  = 2,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h333,
    parameter int                 BLINK_FRAMES = 32,
    parameter logic               SYNC_IDLE    = 1'b1,
    localparam int                LW           = $clog2(NUM_LAYERS + 1)
) (
    input  logic                          clk_25_175,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pix,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [NUM_LAYERS-1:0]         layer_blink,
    input  logic                          de_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    output logic [COLOR_W-1:0]            pix_out,
    output logic                          de_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [LW-1:0]                 active_layer,
    output logic                          overlap_frame,
    output logic                          blink_phase
);

    localparam int            CW      = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] FC_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [LW-1:0] ACT_BG  = LW'(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] elig;
    logic [COLOR_W-1:0]    sel_pix;
    logic [LW-1:0]         sel_act;
    logic                  seen;
    logic                  multi;
    logic                  overlap_now;

    logic [COLOR_W-1:0]    pix_q [PIPE_STAGES];
    logic [LW-1:0]         act_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] de_q;
    logic [PIPE_STAGES-1:0] hs_q;
    logic [PIPE_STAGES-1:0] vs_q;

    logic [CW-1:0]         frame_cnt;
    logic                  overlap_acc;

    assign elig = layer_valid & layer_enable & ~(layer_blink & {NUM_LAYERS{blink_phase}});

    // Descending scan so the lowest eligible index is the last to write and wins.
    always_comb begin
        sel_pix = BG_COLOR;
        sel_act = ACT_BG;
        seen    = 1'b0;
        multi   = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_pix = layer_pix[i*COLOR_W +: COLOR_W];
                sel_act = LW'(i);
            end
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (elig[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        if (!de_in) begin
            sel_pix = '0;
            sel_act = ACT_BG;
        end
    end

    assign overlap_now = de_in & multi;

    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                pix_q[s] <= '0;
                act_q[s] <= ACT_BG;
                de_q[s]  <= 1'b0;
                hs_q[s]  <= SYNC_IDLE;
                vs_q[s]  <= SYNC_IDLE;
            end
        end else begin
            pix_q[0] <= sel_pix;
            act_q[0] <= sel_act;
            de_q[0]  <= de_in;
            hs_q[0]  <= hsync_in;
            vs_q[0]  <= vsync_in;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                pix_q[s] <= pix_q[s-1];
                act_q[s] <= act_q[s-1];
                de_q[s]  <= de_q[s-1];
                hs_q[s]  <= hs_q[s-1];
                vs_q[s]  <= vs_q[s-1];
            end
        end
    end

    assign pix_out      = pix_q[PIPE_STAGES-1];
    assign active_layer = act_q[PIPE_STAGES-1];
    assign de_out       = de_q[PIPE_STAGES-1];
    assign hsync_out    = hs_q[PIPE_STAGES-1];
    assign vsync_out    = vs_q[PIPE_STAGES-1];

    // An overlap in the frame_start cycle still belongs to the frame being closed.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            frame_cnt     <= '0;
            blink_phase   <= 1'b0;
            overlap_acc   <= 1'b0;
            overlap_frame <= 1'b0;
        end else if (frame_start) begin
            overlap_frame <= overlap_acc | overlap_now;
            overlap_acc   <= 1'b0;
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end else if (overlap_now) begin
            overlap_acc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: stimulus pushes model predictions into queues,
// a negedge monitor pops and compares against the pipelined and per-frame outputs.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int P  = 2;
    localparam int BF = 2;
    localparam int LW = $clog2(NL + 1);

    typedef struct {
        logic [11:0]   pix;
        logic          de;
        logic          hs;
        logic          vs;
        logic [LW-1:0] act;
    } pix_exp_t;

    typedef struct {
        logic phase;
        logic ovf;
    } st_exp_t;

    logic          clk_25_175;
    logic          reset;
    logic          frame_start;
    logic [47:0]   layer_pix;
    logic [3:0]    layer_valid;
    logic [3:0]    layer_enable;
    logic [3:0]    layer_blink;
    logic          de_in;
    logic          hsync_in;
    logic          vsync_in;
    logic [11:0]   pix_out;
    logic          de_out;
    logic          hsync_out;
    logic          vsync_out;
    logic [LW-1:0] active_layer;
    logic          overlap_frame;
    logic          blink_phase;

    pix_exp_t exp_q[$];
    st_exp_t  st_q[$];

    int n_total = 0;
    int n_pass  = 0;

    logic m_phase;
    int   m_fc;
    logic m_acc;
    logic m_ovf;

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .COLOR_W     (12),
        .PIPE_STAGES (P),
        .BG_COLOR    (12'h333),
        .BLINK_FRAMES(BF),
        .SYNC_IDLE   (1'b1)
    ) dut (
        .clk_25_175   (clk_25_175),
        .reset        (reset),
        .frame_start  (frame_start),
        .layer_pix    (layer_pix),
        .layer_valid  (layer_valid),
        .layer_enable (layer_enable),
        .layer_blink  (layer_blink),
        .de_in        (de_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .pix_out      (pix_out),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .active_layer (active_layer),
        .overlap_frame(overlap_frame),
        .blink_phase  (blink_phase)
    );

    initial clk_25_175 = 1'b0;
    always #5 clk_25_175 = ~clk_25_175;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        else n_pass++;
    endtask

    // Applies one pixel's inputs, predicts the result from the behavioural rules, then
    // advances one clock.
    task automatic drive(input logic r, input logic fs, input logic [47:0] pix,
                         input logic [3:0] v, input logic [3:0] en, input logic [3:0] bl,
                         input logic de, input logic hs, input logic vs);
        pix_exp_t   e;
        st_exp_t    s;
        logic [3:0] el;
        int         k;
        reset        = r;
        frame_start  = fs;
        layer_pix    = pix;
        layer_valid  = v;
        layer_enable = en;
        layer_blink  = bl;
        de_in        = de;
        hsync_in     = hs;
        vsync_in     = vs;
        if (!r) begin
            m_phase = 1'b0;
            m_fc    = 0;
            m_acc   = 1'b0;
            m_ovf   = 1'b0;
            e = '{pix: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1, act: LW'(NL)};
            // Pixels still in flight when reset hits are wiped, never emerging.
            for (int q = 1; q < exp_q.size(); q++) exp_q[q] = e;
        end else begin
            el = v & en;
            if (m_phase) el = el & ~bl;
            e.de = de;
            e.hs = hs;
            e.vs = vs;
            if (!de) begin
                e.pix = 12'h000;
                e.act = LW'(NL);
            end else if (el == 4'b0000) begin
                e.pix = 12'h333;
                e.act = LW'(NL);
            end else begin
                k = 0;
                while (!el[k]) k++;
                e.pix = pix[k*12 +: 12];
                e.act = LW'(k);
            end
            if (de && $countones(el) >= 2) m_acc = 1'b1;
            if (fs) begin
                m_ovf = m_acc;
                m_acc = 1'b0;
                m_fc  = m_fc + 1;
                if (m_fc == BF) begin
                    m_fc    = 0;
                    m_phase = ~m_phase;
                end
            end
        end
        s.phase = m_phase;
        s.ovf   = m_ovf;
        exp_q.push_back(e);
        st_q.push_back(s);
        @(posedge clk_25_175);
        #1;
    endtask

    always @(negedge clk_25_175) begin : monitor
        pix_exp_t e;
        st_exp_t  s;
        if (exp_q.size() > P) begin
            e = exp_q.pop_front();
            check("pix_out", 32'(pix_out), 32'(e.pix));
            check("active_layer", 32'(active_layer), 32'(e.act));
            check("de_out", 32'(de_out), 32'(e.de));
            check("hsync_out", 32'(hsync_out), 32'(e.hs));
            check("vsync_out", 32'(vsync_out), 32'(e.vs));
        end
        if (st_q.size() > 1) begin
            s = st_q.pop_front();
            check("blink_phase", 32'(blink_phase), 32'(s.phase));
            check("overlap_frame", 32'(overlap_frame), 32'(s.ovf));
        end
    end

    function automatic logic [47:0] rnd_pix();
        return 48'({$urandom, $urandom});
    endfunction

    localparam logic [47:0] PRIO_PIX = {12'hFFF, 12'h0F0, 12'h00F, 12'hF00};

    initial begin
        m_phase = 1'b0;
        m_fc    = 0;
        m_acc   = 1'b0;
        m_ovf   = 1'b0;

        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'($urandom), rnd_pix(), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));

        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'b1110, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'b0000, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'b0001, 4'b1110, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1);

        // Six blink frames: L0 blinks, L1 shows through while L0 is suppressed.
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 5; i++)
                drive(1'b1, i == 0, PRIO_PIX, 4'b0011, 4'hF, 4'b0001, 1'b1, 1'b1, i != 1);

        drive(1'b1, 1'b1, PRIO_PIX, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, PRIO_PIX, (i == 2) ? 4'b0101 : 4'b0100, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, PRIO_PIX, 4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'b1000, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, PRIO_PIX, 4'b0101, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, PRIO_PIX, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, PRIO_PIX, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, PRIO_PIX, 4'b0001, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);

        // One line with a 96-cycle hsync pulse and a DE ramp.
        for (int i = 0; i < 130; i++)
            drive(1'b1, 1'b0, rnd_pix(), 4'($urandom), 4'hF, 4'h0,
                  i >= 110, !(i >= 10 && i < 106), 1'b1);

        for (int i = 0; i < 600; i++) begin
            logic rst_now;
            rst_now = !(i == 300 || i == 301);
            drive(rst_now, ($urandom % 16) == 0, rnd_pix(), 4'($urandom), 4'($urandom),
                  4'($urandom), ($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 16) != 0);
        end

        for (int i = 0; i < P + 2; i++)
            drive(1'b1, 1'b0, 48'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);

        @(negedge clk_25_175);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised successor to the fixed three-way pixstream priority mux in the top level. Merges NUM_LAYERS 12-bit pixel streams (board, speedmeter, score, overlays…) into one VGA pixel stream using fixed index priority, per-layer enable and blink mode. Output is pipelined, with sync/DE delayed to match. Latches a per-frame layer-overlap flag for debug LEDs. Sits between the display producers and VGAcore.

Parameters:
NUM_LAYERS, 4, number of input layers; 2..8; index 0 has the highest priority
COLOR_W, 12, bits per pixel (4R/4G/4B)
PIPE_STAGES, 2, output latency in cycles; 1..4
BG_COLOR, 12'h333, colour when no layer is eligible
BLINK_FRAMES, 32, frame_start pulses per blink half-period; ≥1
SYNC_IDLE, 1'b1, inactive level of hsync/vsync (active-low VGA)

Ports:
clk_25_175  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous active-low reset; logic held in reset while low
frame_start  in  1  one-cycle pulse at the start of each frame
layer_pix  in  NUM_LAYERS*COLOR_W  packed pixels; layer i occupies [i*COLOR_W +: COLOR_W]
layer_valid  in  NUM_LAYERS  layer i claims the current pixel
layer_enable  in  NUM_LAYERS  static per-layer enable
layer_blink  in  NUM_LAYERS  layer i is suppressed while blink_phase=1
de_in  in  1  display-enable for the current pixel
hsync_in  in  1  horizontal sync aligned with the current pixel
vsync_in  in  1  vertical sync aligned with the current pixel
pix_out  out  COLOR_W  composited pixel
de_out  out  1  de_in delayed by PIPE_STAGES cycles
hsync_out  out  1  hsync_in delayed by PIPE_STAGES cycles
vsync_out  out  1  vsync_in delayed by PIPE_STAGES cycles
active_layer  out  LW  winning index, or NUM_LAYERS for background; LW=$clog2(NUM_LAYERS+1)
overlap_frame  out  1  at least one pixel of the previous frame had two or more eligible layers
blink_phase  out  1  current blink phase

Behaviour:
- Reset (reset=0 at a clock edge): every pipeline stage is cleared; pix_out=0, de_out=0, hsync_out=vsync_out=SYNC_IDLE, active_layer=NUM_LAYERS, overlap_frame=0, blink_phase=0, frame counter=0, overlap accumulator=0. Inputs are ignored during reset. Reset asserted mid-frame takes effect on the next edge; no partial pixel leaks out.
- Eligibility: elig[i] = layer_valid[i] & layer_enable[i] & ~(layer_blink[i] & blink_phase).
- Selection (stage 1): the lowest i with elig[i]=1 wins, giving pix=layer_pix[i] and active=i. With no eligible layer, pix=BG_COLOR and active=NUM_LAYERS. When de_in=0, pix=0 and active=NUM_LAYERS regardless of eligibility.
- Pipeline: pix, active, de, hsync and vsync all pass through PIPE_STAGES registers. An input presented at edge N appears on the outputs after edge N+PIPE_STAGES-1, i.e. valid during cycle N+PIPE_STAGES. No stalls; a new pixel enters every cycle.
- Blink: the frame counter increments on each frame_start. When it reaches BLINK_FRAMES-1 and frame_start occurs, the counter returns to 0 and blink_phase toggles. With BLINK_FRAMES=1, blink_phase toggles on every frame_start. The new phase applies from the cycle after the pulse.
- Overlap: the accumulator is set when de_in=1 and popcount(elig)≥2. On frame_start, overlap_frame takes the accumulator value, including any overlap in the same cycle, and the accumulator clears. If an overlap and frame_start coincide, that overlap counts toward the frame being closed.
- Arithmetic: the frame counter is $clog2(BLINK_FRAMES+1) bits and wraps only through the explicit compare.

Test Plan:
- Reset with NUM_LAYERS=4, PIPE_STAGES=2, inputs toggling, reset=0 for 3 cycles → pix_out=0, de_out=0, hsync_out=vsync_out=1, active_layer=4; first post-reset pixel appears 2 cycles after reset rises.
- Priority: de_in=1, valid=4'b1110, enable=4'hF, pixels {L3=FFF, L2=0F0, L1=00F, L0=F00} → pix_out=00F, active_layer=1 two cycles later; valid=0 → pix_out=333, active_layer=4.
- Latency/sync: apply an hsync_in low pulse of 96 cycles and a de_in ramp → hsync_out low for exactly 96 cycles, shifted 2 cycles; same check with PIPE_STAGES=1 and 4.
- Blink: BLINK_FRAMES=2, layer_blink[0]=1, valid=4'b0011 → frames 0–1 show L0, frames 2–3 show L1, frames 4–5 show L0; blink_phase toggles on the 2nd and 4th frame_start.
- Overlap: frame A has one pixel with valid=4'b0101 → overlap_frame=1 after the next frame_start; clean frame B → overlap_frame=0 after the following frame_start; overlap coinciding with frame_start → counted in the closing frame.
- Disabled layer and DE: enable=4'b1110, valid=4'b0001 → background 333; de_in=0 with valid=4'hF → pix_out=000.
